// File: rtl/sysctrl_pkg.sv
// Shared constants for the MCU system-control block: command codes,
// status magic bytes, unmatched-id reply and frame-state saturation.
package sysctrl_pkg;

    typedef enum logic [7:0] {
        CMD_STATUS  = 8'd0,
        CMD_LEDS    = 8'd1,
        CMD_COLOR   = 8'd2,
        CMD_BUTTONS = 8'd3,
        CMD_WRITE   = 8'd4,
        CMD_IRQ     = 8'd5,
        CMD_MASK    = 8'd6,
        CMD_READ    = 8'd7
    } cmd_e;

    localparam logic [7:0] MAGIC_0   = 8'h5C;
    localparam logic [7:0] MAGIC_1   = 8'h42;
    localparam logic [7:0] NO_MATCH  = 8'hFF;
    localparam logic [3:0] STATE_SAT = 4'd15;

    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

endpackage

// File: rtl/sysctrl_gen_if.sv
// MCU byte link: strobe/start/byte towards the block, reply byte back.
// master = MCU side, slave = sysctrl_gen.
interface sysctrl_gen_if;
    logic       data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output data_in_strobe, data_in_start, data_in,
        input  data_out
    );
    modport slave (
        input  data_in_strobe, data_in_start, data_in,
        output data_out
    );
endinterface

// File: rtl/sysctrl_irq.sv
// Interrupt unit: edge detect, pending/mask/coldboot, ack pulse, int_out_n.
// Ports: int_in levels, ack/mask write requests in; int_ack, status, int_out_n out.
module sysctrl_irq
    import sysctrl_pkg::*;
#(
    parameter int NUM_INT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_INT-1:0] int_in,
    input  logic               ack_we,
    input  logic [NUM_INT-1:0] ack_d,
    input  logic               mask_we,
    input  logic [NUM_INT-1:0] mask_d,
    output logic [NUM_INT-1:0] int_ack,
    output logic [7:0]         status,
    output logic               int_out_n
);

    logic [NUM_INT-1:0] prev_q, pend_q, mask_q;
    logic [NUM_INT-1:0] set_v, clr_v, st_v;
    logic               cold_q;

    // bit 0 is the coldboot slot, never a real source
    always_comb begin
        set_v    = int_in & ~prev_q;
        set_v[0] = 1'b0;
        clr_v    = ack_we ? ack_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            cold_q  <= 1'b1;
            int_ack <= '0;
        end else begin
            prev_q  <= int_in;
            // set after clear: a new edge wins over the ack
            pend_q  <= (pend_q & ~clr_v) | set_v;
            if (mask_we) mask_q <= mask_d | NUM_INT'(1);
            if (clr_v[0]) cold_q <= 1'b0;
            int_ack <= clr_v;
        end
    end

    always_comb begin
        st_v    = pend_q & mask_q;
        st_v[0] = cold_q;
        status  = 8'(st_v);
    end

    assign int_out_n = ~(cold_q | (|(pend_q & mask_q)));

endmodule

// File: rtl/sysctrl_gen.sv
// MCU system controller: framed byte commands for status, leds, color,
// buttons, config variables and interrupts. Ports: clk/reset, byte link
// (bus), int_in/int_ack/int_out_n, buttons, leds, color, cfg variable bus.
module sysctrl_gen
    import sysctrl_pkg::*;
#(
    parameter logic [7:0]            CORE_ID      = 8'h05,
    parameter int                    NUM_VARS     = 16,
    parameter logic [NUM_VARS*8-1:0] VAR_IDS      = '0,
    parameter logic [NUM_VARS*8-1:0] VAR_DEFAULTS = '0,
    parameter int                    NUM_INT      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sysctrl_gen_if.slave          bus,
    input  logic [NUM_INT-1:0]    int_in,
    output logic [NUM_INT-1:0]    int_ack,
    output logic                  int_out_n,
    input  logic [1:0]            buttons,
    output logic [1:0]            leds,
    output logic [23:0]           color,
    output logic [NUM_VARS*8-1:0] cfg
);

    logic [3:0]          state_q, state_d;
    cmd_e                cmd_q;
    logic [7:0]          id_q, dout_q, rd_val, irq_status;
    logic [NUM_VARS-1:0] hit_sel;
    logic                start_b, frame_b;

    assign start_b = bus.data_in_strobe & bus.data_in_start;
    assign frame_b = bus.data_in_strobe & ~bus.data_in_start
                   & (state_q != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= 4'd0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_b)
            state_d = 4'd1;
        else if (frame_b && state_q != STATE_SAT)
            state_d = state_q + 4'd1;
    end

    // one-hot select of the lowest-index variable matching id_q
    always_comb begin
        hit_sel = '0;
        rd_val  = NO_MATCH;
        for (int k = NUM_VARS - 1; k >= 0; k--) begin
            if (VAR_IDS[8*k +: 8] == id_q) begin
                hit_sel    = '0;
                hit_sel[k] = 1'b1;
                rd_val     = cfg[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= CMD_STATUS;
            id_q   <= 8'h00;
            dout_q <= 8'h00;
            leds   <= 2'b00;
            color  <= 24'h0;
            cfg    <= VAR_DEFAULTS;
        end else if (start_b) begin
            cmd_q <= cmd_e'(bus.data_in);
        end else if (frame_b) begin
            case (cmd_q)
                CMD_STATUS: begin
                    case (state_q)
                        4'd1:    dout_q <= MAGIC_0;
                        4'd2:    dout_q <= MAGIC_1;
                        4'd3:    dout_q <= CORE_ID;
                        4'd4:    dout_q <= 8'(NUM_VARS);
                        default: dout_q <= 8'h00;
                    endcase
                end
                CMD_LEDS:
                    if (state_q == 4'd1) leds <= bus.data_in[1:0];
                CMD_COLOR: begin
                    case (state_q)
                        4'd1:    color[15:8]  <= bit_rev8(bus.data_in);
                        4'd2:    color[7:0]   <= bit_rev8(bus.data_in);
                        4'd3:    color[23:16] <= bit_rev8(bus.data_in);
                        default: ;
                    endcase
                end
                CMD_BUTTONS:
                    dout_q <= {6'b0, buttons};
                CMD_WRITE: begin
                    if (state_q == 4'd1) id_q <= bus.data_in;
                    if (state_q == 4'd2)
                        for (int k = 0; k < NUM_VARS; k++)
                            if (hit_sel[k]) cfg[8*k +: 8] <= bus.data_in;
                end
                CMD_IRQ:
                    dout_q <= irq_status;
                CMD_READ: begin
                    if (state_q == 4'd1) id_q   <= bus.data_in;
                    if (state_q == 4'd2) dout_q <= rd_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out = dout_q;

    sysctrl_irq #(.NUM_INT(NUM_INT)) u_irq (
        .clk       (clk),
        .reset     (reset),
        .int_in    (int_in),
        .ack_we    (frame_b && cmd_q == CMD_IRQ && state_q == 4'd1),
        .ack_d     (bus.data_in[NUM_INT-1:0]),
        .mask_we   (frame_b && cmd_q == CMD_MASK && state_q == 4'd1),
        .mask_d    (bus.data_in[NUM_INT-1:0]),
        .int_ack   (int_ack),
        .status    (irq_status),
        .int_out_n (int_out_n)
    );

endmodule
